// File: rtl/wf68k00_bus_arbiter.sv
// wf68k00_bus_arbiter: shares the WF68K00 external bus between the CPU and N_REQ alternate
// masters. Runs the BRn/BGn/BGACKn handshake toward the CPU and grants one requester at a
// time in round-robin order. All outputs are registered.
module wf68k00_bus_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned MAX_HOLD = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_REQ-1:0]           req_i,
   output logic [N_REQ-1:0]           gnt_o,
   output logic [$clog2(N_REQ)-1:0]   owner_o,
   output logic                       busy_o,
   output logic                       preempt_o,
   output logic                       br_n_o,
   input  logic                       bg_n_i,
   output logic                       bgack_n_o,
   input  logic                       as_n_i,
   input  logic                       dtack_n_i
);

   localparam int unsigned OwnerW = $clog2(N_REQ);
   localparam int unsigned HcW    = $clog2(MAX_HOLD);
   localparam logic [HcW-1:0] HcMax = HcW'(MAX_HOLD - 1);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StOwn, StRel} state_e;

   state_e              state_q, state_d;
   logic                br_n_q, br_n_d;
   logic                bgack_n_q, bgack_n_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [OwnerW-1:0]   owner_q, owner_d;
   logic                busy_q, busy_d;
   logic                preempt_q, preempt_d;
   logic [OwnerW-1:0]   rr_q, rr_d;
   logic [HcW-1:0]      hc_q, hc_d;

   logic [2*N_REQ-1:0]  req_dbl;
   logic [N_REQ-1:0]    req_rot;
   logic [OwnerW:0]     win_sum;
   logic [OwnerW-1:0]   win_idx;
   logic                bus_free;
   logic                owner_req;
   logic                others_req;

   // Round-robin winner: rotate requests so bit 0 is the RR slot, take the lowest set bit.
   always_comb begin
      req_dbl = {req_i, req_i};
      req_rot = req_dbl[N_REQ-1:0];
      req_rot = N_REQ'(req_dbl >> rr_q);
      win_sum = '0;
      win_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_sum = {1'b0, rr_q} + (OwnerW+1)'(i);
         end
      end
      if (win_sum >= (OwnerW+1)'(N_REQ)) begin
         win_sum = win_sum - (OwnerW+1)'(N_REQ);
      end
      win_idx = win_sum[OwnerW-1:0];
   end

   // Bus-ownership qualifiers; gnt_q is one-hot on the owner while in StOwn.
   always_comb begin
      bus_free   = as_n_i & dtack_n_i & bgack_n_q;
      owner_req  = |(req_i & gnt_q);
      others_req = |(req_i & ~gnt_q);
   end

   // Next-state and registered-output logic for the arbitration handshake.
   always_comb begin
      state_d   = state_q;
      br_n_d    = br_n_q;
      bgack_n_d = bgack_n_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      preempt_d = 1'b0;
      rr_d      = rr_q;
      hc_d      = hc_q;
      unique case (state_q)
         StIdle: begin
            if (|req_i) begin
               state_d = StReq;
               br_n_d  = 1'b0;
            end
         end
         StReq: begin
            if (!(|req_i)) begin
               state_d = StIdle;
               br_n_d  = 1'b1;
            end else if (!bg_n_i) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (!(|req_i)) begin
               state_d = StIdle;
               br_n_d  = 1'b1;
            end else if (bus_free) begin
               state_d   = StOwn;
               gnt_d     = N_REQ'(1) << win_idx;
               owner_d   = win_idx;
               bgack_n_d = 1'b0;
               br_n_d    = 1'b1;
               busy_d    = 1'b1;
               hc_d      = '0;
            end
         end
         StOwn: begin
            if (!owner_req) begin
               // Release beats a coincident preempt.
               state_d   = StRel;
               gnt_d     = '0;
               bgack_n_d = 1'b1;
               busy_d    = 1'b0;
               rr_d      = (owner_q == OwnerW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end else begin
               hc_d      = (hc_q == HcMax) ? hc_q : hc_q + 1'b1;
               preempt_d = (hc_d == HcMax) && others_req;
            end
         end
         StRel: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset releases the bus immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         br_n_q    <= 1'b1;
         bgack_n_q <= 1'b1;
         gnt_q     <= '0;
         owner_q   <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
         rr_q      <= '0;
         hc_q      <= '0;
      end else begin
         state_q   <= state_d;
         br_n_q    <= br_n_d;
         bgack_n_q <= bgack_n_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
         rr_q      <= rr_d;
         hc_q      <= hc_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign owner_o   = owner_q;
   assign busy_o    = busy_q;
   assign preempt_o = preempt_q;
   assign br_n_o    = br_n_q;
   assign bgack_n_o = bgack_n_q;

endmodule

// File: tb/tb_wf68k00_bus_arbiter.sv
// Bench for wf68k00_bus_arbiter: directed handshake scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_wf68k00_bus_arbiter;

   localparam int NR   = 4;
   localparam int HOLD = 8;

   localparam int PIdle = 0;
   localparam int PReq  = 1;
   localparam int PWait = 2;
   localparam int POwn  = 3;
   localparam int PRel  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR-1:0] gnt;
   logic [1:0]    owner;
   logic          busy, preempt, br_n, bgack_n;
   logic          bg_n, as_n, dtack_n;

   int checks = 0;
   int errors = 0;

   // Reference model: where the bus is, who has it, and for how long.
   int m_phase, m_owner, m_rr, m_held;
   bit m_br, m_bgack, m_preempt;

   wf68k00_bus_arbiter #(
      .N_REQ    (NR),
      .MAX_HOLD (HOLD)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .gnt_o     (gnt),
      .owner_o   (owner),
      .busy_o    (busy),
      .preempt_o (preempt),
      .br_n_o    (br_n),
      .bg_n_i    (bg_n),
      .bgack_n_o (bgack_n),
      .as_n_i    (as_n),
      .dtack_n_i (dtack_n)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] r, input int start);
      for (int k = 0; k < NR; k++) begin
         int c;
         c = (start + k) % NR;
         if (((r >> c) & 4'b0001) != 4'b0000) return c;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = PIdle; m_owner = 0; m_rr = 0; m_held = 0;
      m_br = 1'b1; m_bgack = 1'b1; m_preempt = 1'b0;
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_update();
      logic [NR-1:0] mine;
      mine = 4'b0001 << m_owner;
      case (m_phase)
         PIdle: if (req != 0) begin m_phase = PReq; m_br = 1'b0; end
         PReq: begin
            if (req == 0) begin m_phase = PIdle; m_br = 1'b1; end
            else if (!bg_n) m_phase = PWait;
         end
         PWait: begin
            if (req == 0) begin m_phase = PIdle; m_br = 1'b1; end
            else if (as_n && dtack_n && m_bgack) begin
               m_owner = pick(req, m_rr);
               m_phase = POwn; m_bgack = 1'b0; m_br = 1'b1;
               m_held = 0; m_preempt = 1'b0;
            end
         end
         POwn: begin
            if ((req & mine) == 0) begin
               m_phase = PRel; m_bgack = 1'b1; m_preempt = 1'b0;
               m_rr = (m_owner + 1) % NR;
            end else begin
               m_held++;
               m_preempt = (m_held >= HOLD - 1) && ((req & ~mine) != 0);
            end
         end
         default: m_phase = PIdle;
      endcase
   endtask

   task automatic compare_all();
      logic [NR-1:0] eg;
      eg = (m_phase == POwn) ? (4'b0001 << m_owner) : 4'b0000;
      check("gnt",     32'(gnt),     32'(eg));
      check("owner",   32'(owner),   32'(m_owner));
      check("busy",    32'(busy),    32'(m_phase == POwn));
      check("preempt", 32'(preempt), 32'(m_preempt));
      check("br_n",    32'(br_n),    32'(m_br));
      check("bgack_n", 32'(bgack_n), 32'(m_bgack));
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic wait_grant(input int budget);
      int n = 0;
      while (gnt == 4'b0000 && n < budget) begin
         step();
         n++;
      end
      check("grant_seen", 32'(gnt != 4'b0000), 32'd1);
   endtask

   // Asynchronous reset mid-cycle; outputs must drop at once, not on the next edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_bgack_n", 32'(bgack_n), 32'd1);
      check("rst_br_n",    32'(br_n),    32'd1);
      check("rst_gnt",     32'(gnt),     32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_owner",   32'(owner),   32'd0);
      req = 4'b0000; bg_n = 1'b1; as_n = 1'b1; dtack_n = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; bg_n = 1'b1; as_n = 1'b1; dtack_n = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();

      // Idle with no requests: nothing moves.
      repeat (3) step();
      check("idle_br_n", 32'(br_n), 32'd1);

      // Withdraw while waiting for BGn.
      req = 4'b0001;
      step();
      check("wd_br_low", 32'(br_n), 32'd0);
      req = 4'b0000;
      step();
      check("wd_br_high", 32'(br_n), 32'd1);
      repeat (2) step();
      check("wd_no_gnt", 32'(gnt), 32'd0);

      // Single master timeline (cycle 0 = request).
      req = 4'b0100;
      step();
      check("sm_br_c1", 32'(br_n), 32'd0);
      repeat (2) step();
      bg_n = 1'b0;
      step();
      check("sm_gnt_c4", 32'(gnt), 32'd0);
      step();
      check("sm_gnt_c5",   32'(gnt),     32'h4);
      check("sm_owner_c5", 32'(owner),   32'd2);
      check("sm_bgack_c5", 32'(bgack_n), 32'd0);
      check("sm_br_c5",    32'(br_n),    32'd1);
      repeat (5) step();
      req = 4'b0000;
      step();
      check("sm_gnt_c11",   32'(gnt),     32'd0);
      check("sm_bgack_c11", 32'(bgack_n), 32'd1);
      bg_n = 1'b1;
      step();

      // Reset while master 2 owns the bus.
      req = 4'b0100; bg_n = 1'b0;
      wait_grant(10);
      check("pre_rst_gnt", 32'(gnt), 32'h4);
      do_reset();
      repeat (3) step();
      check("post_rst_br_n", 32'(br_n), 32'd1);

      // Bus busy: CPU still strobing, then slave still acknowledging.
      req = 4'b0010; bg_n = 1'b0; as_n = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("busy_as", 32'(gnt), 32'd0);
      end
      as_n = 1'b1; dtack_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("busy_dtack", 32'(gnt), 32'd0);
      end
      dtack_n = 1'b1;
      step();
      check("busy_free_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      repeat (2) step();

      // Round robin with everyone requesting.
      do_reset();
      req = 4'b1111; bg_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         logic [NR-1:0] mine;
         wait_grant(12);
         check("rr_owner", 32'(owner), 32'(k % NR));
         mine = 4'b0001 << (k % NR);
         check("rr_gnt", 32'(gnt), 32'(mine));
         repeat (3) step();
         req = req & ~mine;
         step();
         check("rr_release", 32'(gnt), 32'd0);
         step();
         req = 4'b1111;
      end

      // Preempt: master 0 holds while master 1 waits.
      do_reset();
      req = 4'b0001; bg_n = 1'b0;
      wait_grant(10);
      req = 4'b0011;
      for (int j = 1; j <= 10; j++) begin
         step();
         check("pre_other", 32'(preempt), 32'(j >= HOLD - 1));
      end
      req = 4'b0010;
      step();
      check("pre_drop", 32'(preempt), 32'd0);

      // No other requester: never preempt.
      do_reset();
      req = 4'b0001; bg_n = 1'b0;
      wait_grant(10);
      for (int j = 1; j <= 12; j++) begin
         step();
         check("pre_alone", 32'(preempt), 32'd0);
      end
      req = 4'b0000;
      step();

      // Release on the very cycle preempt would have risen.
      do_reset();
      req = 4'b0001; bg_n = 1'b0;
      wait_grant(10);
      req = 4'b0011;
      repeat (HOLD - 2) step();
      req = 4'b0010;
      step();
      check("race_preempt", 32'(preempt), 32'd0);
      check("race_gnt",     32'(gnt),     32'd0);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < NR; b++) begin
            if ($urandom_range(15) == 0) req = req ^ (4'b0001 << b);
         end
         bg_n    = ($urandom_range(3) == 0);
         as_n    = ($urandom_range(3) != 0);
         dtack_n = ($urandom_range(3) != 0);
         step();
         if (n == 1500) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
